// File: rtl/serial_add_sub_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_add_sub_if : operand/result bus of the digit-serial adder/subtractor
// Rev 1.0
// ---------------------------------------------------------------------------
interface serial_add_sub_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Co;
  logic             V;

  modport master (
    output start, sub, A, B, Ci,
    input  busy, done, S, Co, V
  );

  modport slave (
    input  start, sub, A, B, Ci,
    output busy, done, S, Co, V
  );
endinterface
`default_nettype wire

// File: rtl/serial_add_sub.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_add_sub : digit-serial adder/subtractor, DIGIT bits per cycle
// Rev 1.0
// ---------------------------------------------------------------------------
module serial_add_sub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  serial_add_sub_if.slave bus
);
  localparam int NUM = WIDTH / DIGIT;
  localparam int CW  = (NUM > 1) ? $clog2(NUM) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] s_q;
  logic             co_q;
  logic             v_q;

  logic [DIGIT-1:0] a_sl;
  logic [DIGIT-1:0] b_sl;
  logic [DIGIT:0]   slice_sum;
  logic [WIDTH-1:0] full;
  logic             c_msb_in;

  always_comb begin
    a_sl      = a_q[cnt*DIGIT +: DIGIT];
    b_sl      = b_q[cnt*DIGIT +: DIGIT];
    slice_sum = {1'b0, a_sl} + {1'b0, b_sl} + {{DIGIT{1'b0}}, carry};
    full      = acc;
    full[cnt*DIGIT +: DIGIT] = slice_sum[DIGIT-1:0];
    // Carry into the MSB recovered from the MSB's own sum bit
    c_msb_in  = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ full[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      s_q    <= '0;
      co_q   <= 1'b0;
      v_q    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q    <= bus.A;
            b_q    <= bus.sub ? ~bus.B : bus.B;
            carry  <= bus.sub ? 1'b1 : bus.Ci;
            cnt    <= '0;
            acc    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          acc   <= full;
          carry <= slice_sum[DIGIT];
          if (cnt == CW'(NUM - 1)) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            s_q    <= full;
            co_q   <= slice_sum[DIGIT];
            v_q    <= slice_sum[DIGIT] ^ c_msb_in;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.S    = s_q;
  assign bus.Co   = co_q;
  assign bus.V    = v_q;
endmodule
`default_nettype wire

// File: tb/tb_serial_add_sub.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_serial_add_sub : directed checks of serial_add_sub (WIDTH=16, DIGIT=4)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_serial_add_sub;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  serial_add_sub_if #(.WIDTH(16)) bus ();

  serial_add_sub #(.WIDTH(16), .DIGIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one request in the current cycle, then scramble inputs once accepted
  task automatic start_op(input logic s, input logic [15:0] a, input logic [15:0] b, input logic ci);
    bus.start = 1'b1;
    bus.sub   = s;
    bus.A     = a;
    bus.B     = b;
    bus.Ci    = ci;
    tick();
    bus.start = 1'b0;
    bus.sub   = ~s;
    bus.A     = ~a;
    bus.B     = ~b;
    bus.Ci    = ~ci;
  endtask

  // Called in cycle 1; leaves the bench in cycle 5 (the done cycle)
  task automatic finish_op(input string tag, input logic [15:0] prev_s,
                           input logic [15:0] exp_s, input logic exp_co, input logic exp_v);
    for (int c = 1; c <= 4; c++) begin
      chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
      chk({tag, "_nodone"}, {31'd0, bus.done}, 32'd0);
      chk({tag, "_hold_S"}, {16'd0, bus.S}, {16'd0, prev_s});
      tick();
    end
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd1);
    chk({tag, "_busy_off"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_S"}, {16'd0, bus.S}, {16'd0, exp_s});
    chk({tag, "_Co"}, {31'd0, bus.Co}, {31'd0, exp_co});
    chk({tag, "_V"}, {31'd0, bus.V}, {31'd0, exp_v});
  endtask

  initial begin
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.Ci    = 1'b0;
    tick();
    tick();
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_S",    {16'd0, bus.S},    32'd0);
    chk("rst_CoV",  {30'd0, bus.Co, bus.V}, 32'd0);
    rst = 1'b0;
    tick();

    start_op(1'b0, 16'h1234, 16'h4321, 1'b0);
    finish_op("add_basic", 16'h0000, 16'h5555, 1'b0, 1'b0);
    tick();
    chk("add_basic_pulse", {31'd0, bus.done}, 32'd0);

    start_op(1'b0, 16'hFFFF, 16'h0000, 1'b1);
    finish_op("add_ripple", 16'h5555, 16'h0000, 1'b1, 1'b0);
    tick();

    start_op(1'b0, 16'h7FFF, 16'h0001, 1'b0);
    finish_op("add_ovf", 16'h0000, 16'h8000, 1'b0, 1'b1);
    tick();

    start_op(1'b1, 16'h0005, 16'h0007, 1'b1);
    finish_op("sub_borrow", 16'h8000, 16'hFFFE, 1'b0, 1'b0);
    tick();

    start_op(1'b1, 16'h8000, 16'h0001, 1'b0);
    finish_op("sub_ovf", 16'hFFFE, 16'h7FFF, 1'b1, 1'b1);
    tick();

    // Second start while running must be ignored
    start_op(1'b0, 16'h1234, 16'h4321, 1'b0);
    chk("ign_busy1", {31'd0, bus.busy}, 32'd1);
    tick();
    bus.start = 1'b1;
    bus.sub   = 1'b1;
    bus.A     = 16'hFFFF;
    bus.B     = 16'hFFFF;
    tick();
    bus.start = 1'b0;
    chk("ign_busy3", {31'd0, bus.busy}, 32'd1);
    chk("ign_nodone3", {31'd0, bus.done}, 32'd0);
    tick();
    chk("ign_busy4", {31'd0, bus.busy}, 32'd1);
    tick();
    chk("ign_done", {31'd0, bus.done}, 32'd1);
    chk("ign_S", {16'd0, bus.S}, 32'h5555);
    chk("ign_CoV", {30'd0, bus.Co, bus.V}, 32'd0);
    tick();
    chk("ign_idle_busy", {31'd0, bus.busy}, 32'd0);
    chk("ign_idle_done", {31'd0, bus.done}, 32'd0);

    // Back-to-back: new start in the DONE cycle
    start_op(1'b0, 16'h7FFF, 16'h0001, 1'b0);
    finish_op("b2b_first", 16'h5555, 16'h8000, 1'b0, 1'b1);
    start_op(1'b0, 16'h0001, 16'h0001, 1'b0);
    finish_op("b2b_second", 16'h8000, 16'h0002, 1'b0, 1'b0);
    tick();

    // Reset mid-run, together with a start, aborts without a done pulse
    start_op(1'b0, 16'hFFFF, 16'h0001, 1'b0);
    chk("abort_busy1", {31'd0, bus.busy}, 32'd1);
    tick();
    tick();
    rst       = 1'b1;
    bus.start = 1'b1;
    tick();
    rst       = 1'b0;
    bus.start = 1'b0;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_S",    {16'd0, bus.S},    32'd0);
    chk("abort_CoV",  {30'd0, bus.Co, bus.V}, 32'd0);
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("abort_no_done", {31'd0, bus.done}, 32'd0);
      chk("abort_no_busy", {31'd0, bus.busy}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
